// File: rtl/bram_pkg.sv
// Shared constants and width helpers for the simple-dual-port lane BRAM.
package bram_pkg;

  localparam string MODE_READ_FIRST  = "READ_FIRST";
  localparam string MODE_WRITE_FIRST = "WRITE_FIRST";

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Byte-offset width inside one line.
  function automatic int ofs_w(input int data_width);
    return clog2(data_width / 8);
  endfunction

  // Full byte-address width covering every line.
  function automatic int addr_w(input int data_width, input int depth);
    return clog2((data_width / 8) * depth);
  endfunction

endpackage

// File: rtl/bram_sdp_lanes_if.sv
// Write/read port bundle for bram_sdp_lanes; master drives requests, slave returns read results.
interface bram_sdp_lanes_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_W     = 11,
  parameter int LANE_WIDTH = 16
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [LANE_WIDTH-1:0] rd_lane;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    input  rd_data, rd_lane, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    output rd_data, rd_lane, rd_valid
  );
endinterface

// File: rtl/bram_sdp_array.sv
// Inferred line-wide memory with byte write enables and a registered (read-first) read port.
module bram_sdp_array #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 128,
  parameter int AW         = 7
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_line,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_line,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // No reset here so the array maps onto block RAM; callers gate out-of-range lines.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) mem[wr_line][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data_q <= mem[rd_line];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_sdp_lanes.sv
// Byte-addressed simple-dual-port BRAM with strobed writes, two-stage read pipeline and lane extract.
module bram_sdp_lanes
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 128,
  parameter int    DEPTH          = 128,
  parameter int    LANE_WIDTH     = 16,
  parameter string COLLISION_MODE = MODE_READ_FIRST
) (
  input logic             clk,
  input logic             reset,
  bram_sdp_lanes_if.slave bus
);
  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFS_W       = ofs_w(DATA_WIDTH);
  localparam int ADDR_W      = addr_w(DATA_WIDTH, DEPTH);
  localparam int LINE_W      = ADDR_W - OFS_W;
  localparam int LANE_BYTES  = LANE_WIDTH / 8;
  localparam int LB_W        = clog2(LANE_BYTES);
  localparam int LANES       = DATA_WIDTH / LANE_WIDTH;
  localparam bit WRITE_FIRST = (COLLISION_MODE == MODE_WRITE_FIRST);
  localparam logic [LINE_W:0] DEPTH_L = (LINE_W+1)'(DEPTH);

  logic [LINE_W-1:0]     wr_line, rd_line;
  logic [OFS_W-1:0]      rd_ofs;
  logic                  wr_ok, rd_ok;
  logic                  unused_wr_ofs;
  logic [DATA_WIDTH-1:0] arr_rdata, merged;

  logic                  vld1_q, vld1_d, ok1_q, ok1_d, coll1_q, coll1_d, vld2_q, vld2_d;
  logic [OFS_W-1:0]      ofs1_q, ofs1_d, ofs2_q, ofs2_d;
  logic [BYTES-1:0]      strb1_q, strb1_d;
  logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d, data2_q, data2_d;

  assign wr_line       = bus.wr_addr[ADDR_W-1:OFS_W];
  assign rd_line       = bus.rd_addr[ADDR_W-1:OFS_W];
  assign rd_ofs        = bus.rd_addr[OFS_W-1:0];
  assign unused_wr_ofs = ^bus.wr_addr[OFS_W-1:0];
  assign wr_ok         = bus.wr_en && ({1'b0, wr_line} < DEPTH_L);
  assign rd_ok         = bus.rd_en && ({1'b0, rd_line} < DEPTH_L);

  bram_sdp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (LINE_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_line (wr_line),
    .wr_data (bus.wr_data),
    .wr_strb (bus.wr_strb),
    .rd_en   (rd_ok),
    .rd_line (rd_line),
    .rd_data (arr_rdata)
  );

  always_comb begin
    vld1_d   = bus.rd_en;
    ok1_d    = rd_ok;
    ofs1_d   = bus.rd_en ? rd_ofs : ofs1_q;
    coll1_d  = WRITE_FIRST && wr_ok && rd_ok && (wr_line == rd_line);
    strb1_d  = bus.wr_strb;
    wdata1_d = bus.wr_data;

    // The array returns pre-write data; overlay the colliding write's bytes for write-first.
    merged = arr_rdata;
    for (int b = 0; b < BYTES; b++) begin
      if (coll1_q && strb1_q[b]) merged[8*b +: 8] = wdata1_q[8*b +: 8];
    end

    vld2_d  = vld1_q;
    ofs2_d  = vld1_q ? ofs1_q : ofs2_q;
    data2_d = vld1_q ? (ok1_q ? merged : '0) : data2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld1_q   <= 1'b0;
      ok1_q    <= 1'b0;
      coll1_q  <= 1'b0;
      ofs1_q   <= '0;
      strb1_q  <= '0;
      wdata1_q <= '0;
      vld2_q   <= 1'b0;
      ofs2_q   <= '0;
      data2_q  <= '0;
    end else begin
      vld1_q   <= vld1_d;
      ok1_q    <= ok1_d;
      coll1_q  <= coll1_d;
      ofs1_q   <= ofs1_d;
      strb1_q  <= strb1_d;
      wdata1_q <= wdata1_d;
      vld2_q   <= vld2_d;
      ofs2_q   <= ofs2_d;
      data2_q  <= data2_d;
    end
  end

  always_comb begin
    bus.rd_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      if ((32'(ofs2_q) >> LB_W) == 32'(l)) bus.rd_lane = data2_q[l*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign bus.rd_data  = data2_q;
  assign bus.rd_valid = vld2_q;

endmodule

// File: tb/tb_bram_sdp_lanes.sv
// Scoreboard bench: a READ_FIRST/128-line and a WRITE_FIRST/100-line instance share one stimulus stream.
module tb_bram_sdp_lanes;
  import bram_pkg::*;

  localparam int DW = 128, AW = 11, LW = 16, NB = DW / 8;
  localparam int DEPTH_RF = 128, DEPTH_WF = 100;

  typedef struct {
    logic [DW-1:0] data;
    logic [LW-1:0] lane;
    int            cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_strb = '0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  rec_t exp_rf[$], exp_wf[$], got_rf[$], got_wf[$];
  logic [DW-1:0] m_rf [DEPTH_RF];
  logic [DW-1:0] m_wf [DEPTH_WF];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_sdp_lanes_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .LANE_WIDTH(LW)) if_rf ();
  bram_sdp_lanes_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .LANE_WIDTH(LW)) if_wf ();

  assign if_rf.wr_en = wr_en;  assign if_wf.wr_en = wr_en;
  assign if_rf.wr_addr = wr_addr;  assign if_wf.wr_addr = wr_addr;
  assign if_rf.wr_data = wr_data;  assign if_wf.wr_data = wr_data;
  assign if_rf.wr_strb = wr_strb;  assign if_wf.wr_strb = wr_strb;
  assign if_rf.rd_en = rd_en;  assign if_wf.rd_en = rd_en;
  assign if_rf.rd_addr = rd_addr;  assign if_wf.rd_addr = rd_addr;

  bram_sdp_lanes #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH_RF), .LANE_WIDTH(LW), .COLLISION_MODE(MODE_READ_FIRST)
  ) u_rf (.clk(clk), .reset(reset), .bus(if_rf));

  bram_sdp_lanes #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH_WF), .LANE_WIDTH(LW), .COLLISION_MODE(MODE_WRITE_FIRST)
  ) u_wf (.clk(clk), .reset(reset), .bus(if_wf));

  always @(negedge clk) begin
    if (reset) begin
      if (if_rf.rd_valid) got_rf.push_back('{if_rf.rd_data, if_rf.rd_lane, cyc});
      if (if_wf.rd_valid) got_wf.push_back('{if_wf.rd_data, if_wf.rd_lane, cyc});
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [NB-1:0] strb);
    logic [DW-1:0] r;
    r = old_d;
    for (int b = 0; b < NB; b++) if (strb[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [LW-1:0] lane_of(input logic [DW-1:0] d, input logic [AW-1:0] a);
    int idx;
    idx = int'(a[3:0]) / (LW / 8);
    return d[idx*LW +: LW];
  endfunction

  // One cycle of stimulus; models read-first vs write-first ordering and pushes expectations.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] ws, input logic re, input logic [AW-1:0] ra);
    int   wl, rl;
    rec_t r;
    wl = int'(wa >> 4);
    rl = int'(ra >> 4);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_en = re; rd_addr = ra;
    r.cyc = cyc + 2;
    if (re) begin
      r.data = (rl < DEPTH_RF) ? m_rf[rl] : '0;
      r.lane = lane_of(r.data, ra);
      exp_rf.push_back(r);
    end
    if (we && wl < DEPTH_RF) m_rf[wl] = merge(m_rf[wl], wd, ws);
    if (we && wl < DEPTH_WF) m_wf[wl] = merge(m_wf[wl], wd, ws);
    if (re) begin
      r.data = (rl < DEPTH_WF) ? m_wf[rl] : '0;
      r.lane = lane_of(r.data, ra);
      exp_wf.push_back(r);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) reset = 1'b1;
      @(negedge clk);
      checks++;
      if (if_rf.rd_valid !== 1'b0 || if_rf.rd_data !== '0 || if_rf.rd_lane !== '0) begin
        errors++;
        $display("FAIL reset_idle_rf[%0d]: valid=%b data=%h lane=%h, want all 0", i,
                 if_rf.rd_valid, if_rf.rd_data, if_rf.rd_lane);
      end
      checks++;
      if (if_wf.rd_valid !== 1'b0 || if_wf.rd_data !== '0 || if_wf.rd_lane !== '0) begin
        errors++;
        $display("FAIL reset_idle_wf[%0d]: valid=%b data=%h lane=%h, want all 0", i,
                 if_wf.rd_valid, if_wf.rd_data, if_wf.rd_lane);
      end
    end
  endtask

  task automatic test_lanes();
    drive(1'b1, 11'h050, 128'h00FF_EEDD_CCBB_AA99_8877_6655_4433_2211, 16'hFFFF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h050);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h052);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h05E);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL lanes[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL lanes[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  task automatic test_partial();
    drive(1'b1, 11'h050, {16{8'hAA}}, 16'h0003, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h050);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h05C);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL partial[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL partial[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  task automatic test_collision();
    drive(1'b1, 11'h070, {16{8'h22}}, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 11'h070, {16{8'h11}}, 16'h00FF, 1'b1, 11'h070);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h07E);
    drive(1'b1, 11'h070, {16{8'h33}}, 16'h0000, 1'b1, 11'h072);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL collision[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL collision[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  // Line 100 and 127 are in range only for the 128-line instance; line 36 catches address wrap.
  task automatic test_range();
    drive(1'b1, 11'h630, {8{16'h9963}}, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 11'h240, {16{8'h36}}, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 11'h640, {16{8'hEE}}, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 11'h7F0, {16{8'h7F}}, 16'hFFFF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h640);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h632);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h240);
    drive(1'b1, 11'h64E, {16{8'h55}}, 16'hFFFF, 1'b1, 11'h7FF);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL range[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL range[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  task automatic test_reset_flight();
    drive(1'b1, 11'h030, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 16'hFFFF, 1'b0, '0);
    idle(1);
    drive(1'b0, '0, '0, '0, 1'b1, 11'h034);
    // Mid-cycle of the second read: both reads must vanish.
    rd_en = 1'b1;
    rd_addr = 11'h03A;
    reset = 1'b0;
    exp_rf.delete();
    exp_wf.delete();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(posedge clk);
        #2 reset = 1'b1;
      end
      @(negedge clk);
      rd_en = 1'b0;
      checks++;
      if (if_rf.rd_valid !== 1'b0 || if_rf.rd_data !== '0 || if_rf.rd_lane !== '0) begin
        errors++;
        $display("FAIL flight_rf[%0d]: valid=%b data=%h lane=%h, want all 0", i,
                 if_rf.rd_valid, if_rf.rd_data, if_rf.rd_lane);
      end
      checks++;
      if (if_wf.rd_valid !== 1'b0 || if_wf.rd_data !== '0 || if_wf.rd_lane !== '0) begin
        errors++;
        $display("FAIL flight_wf[%0d]: valid=%b data=%h lane=%h, want all 0", i,
                 if_wf.rd_valid, if_wf.rd_data, if_wf.rd_lane);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 11'h03C);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL flight[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL flight[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < 8; l++)
      drive(1'b1, AW'(l * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, '0);
    for (int i = 0; i < 48; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 16),
            {$urandom, $urandom, $urandom, $urandom}, NB'($urandom),
            1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 127)));
    idle(4);
    for (int k = 0; k < 2; k++) begin
      rec_t e[$];
      rec_t g[$];
      rec_t x, y;
      if (k == 0) begin e = exp_rf; g = got_rf; end
      else begin e = exp_wf; g = got_wf; end
      checks++;
      if (g.size() != e.size()) begin
        errors++;
        $display("FAIL b2b[%0d] count: got %0d results, want %0d", k, g.size(), e.size());
      end
      while (e.size() > 0 && g.size() > 0) begin
        x = e.pop_front();
        y = g.pop_front();
        checks++;
        if (y.data !== x.data || y.lane !== x.lane || y.cyc !== x.cyc) begin
          errors++;
          $display("FAIL b2b[%0d]: got data=%h lane=%h cyc=%0d, want data=%h lane=%h cyc=%0d",
                   k, y.data, y.lane, y.cyc, x.data, x.lane, x.cyc);
        end
      end
    end
    exp_rf.delete(); exp_wf.delete(); got_rf.delete(); got_wf.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_lanes();
    test_partial();
    test_collision();
    test_range();
    test_reset_flight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
